// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes and muldiv sequencer types
package alu_pkg;

    typedef logic [2:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD = 3'b000;
    localparam alu_ctrl_t ALU_SUB = 3'b001;
    localparam alu_ctrl_t ALU_AND = 3'b010;
    localparam alu_ctrl_t ALU_OR  = 3'b011;
    localparam alu_ctrl_t ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REMU = 2'b10,
        OP_RSVD = 2'b11
    } muldiv_op_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MUL     = 3'd1,
        S_DIV_CMP = 3'd2,
        S_DIV_SUB = 3'd3,
        S_DONE    = 3'd4
    } muldiv_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - shared single-cycle ALU driven by the decoder or the muldiv sequencer
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

    // SLT is an unsigned compare; the restoring divider depends on that.
    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - iterative unsigned MUL/DIVU/REMU that borrows the shared ALU
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic                  alu_busy,
    output logic [2:0]            alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    input  logic [DATA_WIDTH-1:0] alu_out
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = '1;

    muldiv_state_t         state_q, state_d;
    muldiv_op_t            op_q, op_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] div_q, div_d;
    logic                  lt_q, lt_d;
    logic [DATA_WIDTH:0]   shifted;

    // The bit shifted out of rem is only needed for the compare, so rem is
    // stored at DATA_WIDTH bits and the overflow bit lives in shifted.
    assign shifted = {rem_q, quo_q[DATA_WIDTH-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            lt_q     <= lt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        lt_d     = lt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = muldiv_op_t'(req_op);
                    count_d = '0;
                    case (muldiv_op_t'(req_op))
                        OP_MUL: begin
                            acc_d    = '0;
                            mcand_d  = req_a;
                            mplier_d = req_b;
                            state_d  = S_MUL;
                        end
                        OP_DIVU, OP_REMU: begin
                            rem_d   = '0;
                            quo_d   = req_a;
                            div_d   = req_b;
                            state_d = S_DIV_CMP;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_MUL: begin
                if (mplier_q[0]) acc_d = alu_out;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == CNT_LAST) state_d = S_DONE;
            end
            S_DIV_CMP: begin
                rem_d   = shifted[DATA_WIDTH-1:0];
                quo_d   = {quo_q[DATA_WIDTH-2:0], 1'b0};
                lt_d    = alu_out[0] && !shifted[DATA_WIDTH];
                state_d = S_DIV_SUB;
            end
            S_DIV_SUB: begin
                // Wrapping subtract is still exact when the shifted-out bit was set.
                if (!lt_q) begin
                    rem_d    = alu_out;
                    quo_d[0] = 1'b1;
                end
                count_d = count_q + 1'b1;
                state_d = (count_q == CNT_LAST) ? S_DONE : S_DIV_CMP;
            end
            S_DONE: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == S_IDLE);
        resp_valid  = (state_q == S_DONE);
        resp_result = '0;
        alu_busy    = 1'b0;
        alu_ctrl    = ALU_ADD;
        alu_op1     = '0;
        alu_op2     = '0;
        case (state_q)
            S_MUL: begin
                alu_busy = 1'b1;
                alu_ctrl = ALU_ADD;
                alu_op1  = acc_q;
                alu_op2  = mcand_q;
            end
            S_DIV_CMP: begin
                alu_busy = 1'b1;
                alu_ctrl = ALU_SLT;
                alu_op1  = shifted[DATA_WIDTH-1:0];
                alu_op2  = div_q;
            end
            S_DIV_SUB: begin
                alu_busy = 1'b1;
                alu_ctrl = ALU_SUB;
                alu_op1  = rem_q;
                alu_op2  = div_q;
            end
            S_DONE: begin
                case (op_q)
                    OP_MUL:  resp_result = acc_q;
                    OP_DIVU: resp_result = quo_q;
                    OP_REMU: resp_result = rem_q;
                    default: resp_result = '0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb/tb_alu_seq_muldiv.sv - randomized self-checking bench for alu_seq_muldiv with the shared ALU
module tb_alu_seq_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        alu_busy;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq_muldiv #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .alu_busy(alu_busy), .alu_ctrl(alu_ctrl), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_out(alu_out)
    );

    alu #(.DATA_WIDTH(32)) u_alu (
        .alu_ctrl(alu_ctrl), .a(alu_op1), .b(alu_op2), .result(alu_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] prod;
        prod = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return prod[31:0];
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_resp_result"}, resp_result, 32'd0);
        chk({tag, "_alu_busy"}, {31'd0, alu_busy}, 32'd0);
        chk({tag, "_alu_ctrl"}, {29'd0, alu_ctrl}, 32'd0);
        chk({tag, "_alu_op1"}, alu_op1, 32'd0);
        chk({tag, "_alu_op2"}, alu_op2, 32'd0);
    endtask

    // Issue one request, measure latency/busy cycles, optionally stall the response.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int stall);
        logic [31:0] exp;
        int lat;
        int busy_cnt;
        exp = ref_model(op, a, b);
        @(negedge clk);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        lat       = 0;
        busy_cnt  = 0;
        while (!resp_valid && lat < 200) begin
            if (alu_busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 200) begin
            chk({tag, "_timeout"}, 32'(lat), 32'd0);
            return;
        end
        if (op == 2'b00) begin
            chk({tag, "_latency"}, 32'(lat), 32'd32);
            chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd32);
        end else if (op != 2'b11) begin
            chk({tag, "_latency"}, 32'(lat), 32'd64);
            chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd64);
        end
        chk({tag, "_result"}, resp_result, exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_stall_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({tag, "_stall_result"}, resp_result, exp);
            chk({tag, "_stall_req_ready"}, {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, "_back_idle"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        do_op("mul_7x6", 2'b00, 32'd7, 32'd6, 0);
        do_op("mul_trunc", 2'b00, 32'hFFFF_FFFF, 32'd2, 0);
        do_op("mul_wrap0", 2'b00, 32'h0001_0000, 32'h0001_0000, 0);
        do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0);
        do_op("remu_100_7", 2'b10, 32'd100, 32'd7, 0);
        do_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 0);
        do_op("remu_big", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 0);
        do_op("divu_by0", 2'b01, 32'd5, 32'd0, 0);
        do_op("remu_by0", 2'b10, 32'd5, 32'd0, 0);
        do_op("rsvd", 2'b11, 32'd123, 32'd45, 0);
        do_op("mul_stall", 2'b00, 32'h1234_5678, 32'h9ABC_DEF1, 5);

        // Reset in the middle of a multiply.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd99;
        req_b     = 32'd77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("midrst_busy_before", {31'd0, alu_busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("midrst");
        do_op("after_rst", 2'b01, 32'd1000, 32'd33, 0);

        for (int n = 0; n < 30; n++) begin
            rop = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) rop = 2'b11;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 15));
                1:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            do_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
